// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq -- PLL reset sequencer and lock monitor
//
// This block runs on the free-running board clock that also feeds the PLL
// input. It pulses the PLL reset, waits for a qualified lock, holds the
// system in reset for a settle delay, and then releases it. If lock is lost
// after qualification, it puts the system back into reset. It retries the
// PLL bring-up whenever lock does not arrive before a timeout.
//
// Ports
//   clk          in   free-running board clock
//   rst          in   synchronous reset, active-high
//   pll_lock_i   in   PLL lock, asynchronous to clk (synchronised internally)
//   pll_rst_o    out  PLL reset, active-high
//   sys_rst_o    out  system reset, active-high
//   ready_o      out  high only while running with a qualified lock
//   lock_lost_o  out  one-cycle pulse when a qualified lock drops
//   retry_cnt_o  out  number of lock timeouts, saturating at 255
//
// Configuration macro
//   PLL_RST_SEQ_AUTO_RECOVER_EN
//     defined   : a lock loss restarts the full PLL bring-up automatically
//     undefined : a lock loss parks the block in FAULT until rst is applied
// -----------------------------------------------------------------------------
module pll_rst_seq #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned RELEASE_DLY_CYC  = 64,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    S_PRST      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  // Each phase ends on the cycle where the counter holds its last value.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DLY_CYC - 1);

`ifdef PLL_RST_SEQ_AUTO_RECOVER_EN
  localparam state_t LOSS_STATE = S_PRST;
`else
  localparam state_t LOSS_STATE = S_FAULT;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             lock_s_q;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             ready_q;
  logic             lock_lost_q;
  logic [7:0]       retry_cnt_q;
  logic [7:0]       retry_cnt_d;

  // Saturating increment of the timeout counter.
  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (retry_cnt_q == 8'hFF) begin
      retry_cnt_d = retry_cnt_q;
    end else begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end
  end

  // Lock synchroniser, sequencing FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PRST;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_cnt_q <= 8'd0;
    end else begin
      sync1_q     <= pll_lock_i;
      lock_s_q    <= sync1_q;
      lock_lost_q <= 1'b0;
      case (state_q)
        S_PRST: begin
          if (cnt_q == PULSE_LAST) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock is checked first, so it wins on the timeout cycle.
          if (lock_s_q) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            retry_cnt_q <= retry_cnt_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // A glitch before qualification only restarts the wait.
          if (!lock_s_q) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!lock_s_q) begin
            state_q     <= LOSS_STATE;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
          end else if (cnt_q == RELEASE_LAST) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_q     <= LOSS_STATE;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q;
          end
        end
        S_FAULT: begin
          // Parked with everything held in reset; only rst leaves.
          state_q   <= S_FAULT;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
        default: begin
          state_q   <= S_PRST;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq -- directed self-checking bench for pll_rst_seq
//
// Uses small cycle parameters. Cycle n is the state just after the n-th rising
// edge following the last reset edge. Outputs are sampled 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] retry_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pll_rst_seq #(
    .RST_PULSE_CYC    (4),
    .LOCK_TIMEOUT_CYC (20),
    .LOCK_STABLE_CYC  (8),
    .RELEASE_DLY_CYC  (5),
    .CNT_W            (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock_i  (pll_lock_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_o   (sys_rst_o),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o),
    .retry_cnt_o (retry_cnt_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    check_eq("rst_pll_rst", {31'd0, pll_rst_o}, 32'd1);
    check_eq("rst_sys_rst", {31'd0, sys_rst_o}, 32'd1);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
    check_eq("rst_lock_lost", {31'd0, lock_lost_o}, 32'd0);
    check_eq("rst_retry", {24'd0, retry_cnt_o}, 32'd0);
  endtask

  // Clean bring-up with lock arriving at edge 10; system released at cycle 25.
  task automatic bring_up();
    run_to(3);
    check_eq("bu_pll_rst_hi", {31'd0, pll_rst_o}, 32'd1);
    run_to(4);
    check_eq("bu_pll_rst_lo", {31'd0, pll_rst_o}, 32'd0);
    run_to(9);
    pll_lock_i = 1'b1;
    run_to(24);
    check_eq("bu_sys_rst_held", {31'd0, sys_rst_o}, 32'd1);
    check_eq("bu_ready_held", {31'd0, ready_o}, 32'd0);
    run_to(25);
    check_eq("bu_sys_rst_rel", {31'd0, sys_rst_o}, 32'd0);
    check_eq("bu_ready", {31'd0, ready_o}, 32'd1);
    check_eq("bu_retry", {24'd0, retry_cnt_o}, 32'd0);
  endtask

  // Invariants: ready and PLL reset are exclusive; sys reset is low only when ready.
  always @(negedge clk) begin
    check_eq("inv_excl", {31'd0, pll_rst_o & ready_o}, 32'd0);
    check_eq("inv_sys_ready", {31'd0, sys_rst_o}, {31'd0, ~ready_o});
  end

  initial begin
    rst        = 1'b1;
    pll_lock_i = 1'b0;

    // Clean bring-up.
    do_reset();
    bring_up();

    // Lock loss in RUN: input drops before edge 31, seen by the FSM at edge 33.
    run_to(30);
    pll_lock_i = 1'b0;
    run_to(32);
    check_eq("loss_pre_pulse", {31'd0, lock_lost_o}, 32'd0);
    check_eq("loss_pre_ready", {31'd0, ready_o}, 32'd1);
    run_to(33);
    check_eq("loss_pulse", {31'd0, lock_lost_o}, 32'd1);
    check_eq("loss_sys_rst", {31'd0, sys_rst_o}, 32'd1);
    check_eq("loss_ready", {31'd0, ready_o}, 32'd0);
    check_eq("loss_pll_rst", {31'd0, pll_rst_o}, 32'd1);
    pll_lock_i = 1'b1;
    run_to(34);
    check_eq("loss_pulse_end", {31'd0, lock_lost_o}, 32'd0);
`ifdef PLL_RST_SEQ_AUTO_RECOVER_EN
    run_to(36);
    check_eq("ar_pll_rst_hi", {31'd0, pll_rst_o}, 32'd1);
    run_to(37);
    check_eq("ar_pll_rst_lo", {31'd0, pll_rst_o}, 32'd0);
    run_to(50);
    check_eq("ar_sys_rst_held", {31'd0, sys_rst_o}, 32'd1);
    run_to(51);
    check_eq("ar_sys_rst_rel", {31'd0, sys_rst_o}, 32'd0);
    check_eq("ar_ready", {31'd0, ready_o}, 32'd1);
    check_eq("ar_retry", {24'd0, retry_cnt_o}, 32'd0);
`else
    run_to(37);
    check_eq("flt_pll_rst_a", {31'd0, pll_rst_o}, 32'd1);
    run_to(51);
    check_eq("flt_sys_rst", {31'd0, sys_rst_o}, 32'd1);
    check_eq("flt_ready", {31'd0, ready_o}, 32'd0);
    run_to(80);
    check_eq("flt_pll_rst_b", {31'd0, pll_rst_o}, 32'd1);
    check_eq("flt_lock_lost", {31'd0, lock_lost_o}, 32'd0);
    check_eq("flt_retry", {24'd0, retry_cnt_o}, 32'd0);
    pll_lock_i = 1'b0;
    do_reset();
    bring_up();
`endif

    // Glitch in STABLE: lock high for 5 samples, low for 1, then high again.
    pll_lock_i = 1'b0;
    do_reset();
    run_to(9);
    pll_lock_i = 1'b1;
    run_to(14);
    pll_lock_i = 1'b0;
    run_to(15);
    pll_lock_i = 1'b1;
    run_to(17);
    check_eq("gl_no_lost_a", {31'd0, lock_lost_o}, 32'd0);
    run_to(18);
    check_eq("gl_no_lost_b", {31'd0, lock_lost_o}, 32'd0);
    run_to(25);
    check_eq("gl_sys_rst_25", {31'd0, sys_rst_o}, 32'd1);
    run_to(30);
    check_eq("gl_sys_rst_30", {31'd0, sys_rst_o}, 32'd1);
    run_to(31);
    check_eq("gl_sys_rst_rel", {31'd0, sys_rst_o}, 32'd0);
    check_eq("gl_retry", {24'd0, retry_cnt_o}, 32'd0);

    // One-cycle rst during RELEASE, then a restart with lock already present.
    pll_lock_i = 1'b0;
    do_reset();
    run_to(9);
    pll_lock_i = 1'b1;
    run_to(21);
    rst = 1'b1;
    run_to(22);
    rst = 1'b0;
    cyc = 0;
    check_eq("mid_pll_rst", {31'd0, pll_rst_o}, 32'd1);
    check_eq("mid_sys_rst", {31'd0, sys_rst_o}, 32'd1);
    check_eq("mid_ready", {31'd0, ready_o}, 32'd0);
    check_eq("mid_lock_lost", {31'd0, lock_lost_o}, 32'd0);
    run_to(3);
    check_eq("mid_pll_rst_hi", {31'd0, pll_rst_o}, 32'd1);
    run_to(4);
    check_eq("mid_pll_rst_lo", {31'd0, pll_rst_o}, 32'd0);
    run_to(17);
    check_eq("mid_sys_rst_held", {31'd0, sys_rst_o}, 32'd1);
    run_to(18);
    check_eq("mid_sys_rst_rel", {31'd0, sys_rst_o}, 32'd0);

    // Timeout retries: 24-cycle period, saturating at 255.
    pll_lock_i = 1'b0;
    do_reset();
    run_to(23);
    check_eq("to_retry_0", {24'd0, retry_cnt_o}, 32'd0);
    check_eq("to_pll_rst_lo", {31'd0, pll_rst_o}, 32'd0);
    run_to(24);
    check_eq("to_retry_1", {24'd0, retry_cnt_o}, 32'd1);
    check_eq("to_pll_rst_hi", {31'd0, pll_rst_o}, 32'd1);
    run_to(27);
    check_eq("to_pulse_end_hi", {31'd0, pll_rst_o}, 32'd1);
    run_to(28);
    check_eq("to_pulse_end_lo", {31'd0, pll_rst_o}, 32'd0);
    run_to(48);
    check_eq("to_retry_2", {24'd0, retry_cnt_o}, 32'd2);
    run_to(72);
    check_eq("to_retry_3", {24'd0, retry_cnt_o}, 32'd3);
    run_to(6119);
    check_eq("to_retry_254", {24'd0, retry_cnt_o}, 32'd254);
    run_to(6120);
    check_eq("to_retry_255", {24'd0, retry_cnt_o}, 32'd255);
    run_to(7200);
    check_eq("to_retry_sat", {24'd0, retry_cnt_o}, 32'd255);
    check_eq("to_sys_rst", {31'd0, sys_rst_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("to_retry_clr", {24'd0, retry_cnt_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
